apb_slave_regbank: RTL and testbench
====================================

Name: apb_slave_regbank

Overview:
- APB slave that sits directly downstream of the APB bridge and consumes its Pselx/Penable/Pwrite/Paddr/Pwdata outputs.
- Returns Prdata from a bank of DEPTH 32-bit registers.
- Tracks APB phases with a small state machine, counts completed transfers, and optionally flags protocol violations.
- Several instances, each on a different Pselx bit, form the peripheral side of the subsystem.

Parameters:
- SEL_IDX, 0, index of the Pselx bit that selects this slave.
- DEPTH, 16, number of 32-bit registers; power of 2, range 2..256.
- BASE_ADDR, 32'h8000_0000, byte base of the register window; aligned to DEPTH*4.
- RESET_VAL, 32'h0, reset value of every register.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- Pselx  input  32  one-hot slave selects; only bit SEL_IDX is used.
- Penable  input  1  APB access-phase strobe.
- Pwrite  input  1  1 = write, 0 = read.
- Paddr  input  32  byte address.
- Pwdata  input  32  write data.
- Prdata  output  32  read data, registered.
- xfer_done  output  1  one-cycle pulse at the end of each completed access phase.
- xfer_cnt  output  16  count of completed transfers; wraps at 16'hFFFF -> 0.
- prot_err  output  1  sticky protocol-violation flag; tied 0 when the optional feature is off.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous, active-high.
- While rst is high:
  - state = IDLE.
  - Prdata = 0, xfer_done = 0, xfer_cnt = 0, prot_err = 0.
  - All registers = RESET_VAL.
- Reset asserted mid-transfer aborts it: no write commits, no count.
- Define sel = Pselx[SEL_IDX]. Word index = Paddr[$clog2(DEPTH)+1:2]. Paddr[1:0] is ignored.
- hit = Paddr[31:$clog2(DEPTH)+2] equals the same bits of BASE_ADDR.
- State machine (states IDLE, SETUP, ACCESS):
  - IDLE -> SETUP when sel && !Penable.
  - SETUP -> ACCESS when sel && Penable.
  - SETUP -> IDLE otherwise (aborted setup).
  - ACCESS -> SETUP when sel && !Penable (back-to-back transfer).
  - ACCESS -> IDLE when !sel.
  - ACCESS -> ACCESS when sel && Penable: treated as a repeated access, no new commit.
  - IDLE with sel && Penable stays IDLE; the cycle is ignored.
- Read:
  - At the rising edge that ends SETUP with Pwrite=0, Prdata <= hit ? reg[idx] : 0.
  - Prdata is therefore valid throughout the ACCESS cycle; latency = 1 cycle from setup.
  - At the edge leaving ACCESS, Prdata <= 0, so multiple slaves can be OR-combined.
- Write:
  - Commits at the rising edge that ends ACCESS with Pwrite=1 and hit; misses are dropped.
  - Address and data are taken from the ACCESS cycle.
- Write followed immediately by read of the same word: the read returns the new value, because the write commits before the read's setup edge.
- xfer_done pulses high for the cycle after each ACCESS end (hits and misses). xfer_cnt increments on the same edge.
- The APB bus has no wait states: every access phase is exactly one cycle.

Optional Feature:
- Macro: APB_SLV_PROT_CHK_EN.
- When defined, prot_err is set and held until rst on any of:
  - Penable=1 with sel while in IDLE.
  - SETUP not followed by sel && Penable.
  - Paddr, Pwrite or Pwdata (writes only) changing between SETUP and ACCESS.
  - Penable held high for two consecutive cycles on the same transfer.
- Data-path behaviour is identical with or without the checker.
- When undefined, the checker logic is absent and prot_err is constant 0.

Decomposition:
- Package apb_slv_pkg holds:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t.
  - localparams APB_ADDR_W=32, APB_DATA_W=32, XFER_CNT_W=16.
- One sub-module, apb_slv_prot_chk: the optional checker. It is instantiated only under the macro, takes state plus the bus inputs, and outputs prot_err.

Test Plan:
- Reset then read idx 3 (Paddr=32'h8000_000C) -> Prdata=0 in ACCESS, xfer_done pulse, xfer_cnt=1.
- Write 32'hDEAD_BEEF to 32'h8000_0010, then read it back-to-back -> Prdata=32'hDEAD_BEEF in the read ACCESS cycle, xfer_cnt=2.
- Write 32'h1234_5678 to 32'h9000_0000 (miss), then read 32'h8000_0000 -> register unchanged, miss read returns 0, both transfers counted.
- Pselx bit != SEL_IDX with valid setup/access -> no state change, Prdata stays 0, xfer_cnt unchanged.
- Assert rst during ACCESS of a write of 32'hA5A5_A5A5 -> register stays RESET_VAL, all outputs 0 immediately without waiting for a clock edge.
- With APB_SLV_PROT_CHK_EN, Penable=1 in IDLE, or Paddr changed 0x04 -> 0x08 between SETUP and ACCESS -> prot_err=1 and sticky; without the macro -> prot_err=0.

Source files
------------

// File: rtl/apb_slv_pkg.sv
// Shared types and widths for the APB slave register bank and its protocol checker.
package apb_slv_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int XFER_CNT_W = 16;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
endpackage

// File: rtl/apb_slv_prot_chk.sv
// Sticky APB protocol-violation detector; only instantiated by apb_slave_regbank when
// APB_SLV_PROT_CHK_EN is defined.
module apb_slv_prot_chk
  import apb_slv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  apb_state_t            state,
  input  logic                  sel,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [APB_ADDR_W-1:0] Paddr,
  input  logic [APB_DATA_W-1:0] Pwdata,
  output logic                  prot_err
);

  logic [APB_ADDR_W-1:0] addr_reg;
  logic [APB_DATA_W-1:0] wdata_reg;
  logic                  write_reg;
  logic                  err_reg;
  logic                  viol;
  logic                  access_now;

  assign access_now = sel && Penable;

  // state is the phase of the previous cycle, so the *_reg copies hold the setup-cycle values
  always_comb begin
    viol = 1'b0;
    case (state)
      IDLE:    viol = access_now;
      SETUP:   viol = !access_now || (Paddr != addr_reg) || (Pwrite != write_reg) ||
                      (Pwrite && (Pwdata != wdata_reg));
      ACCESS:  viol = access_now;
      default: viol = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      write_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      addr_reg  <= Paddr;
      wdata_reg <= Pwdata;
      write_reg <= Pwrite;
      if (viol) err_reg <= 1'b1;
    end
  end

  assign prot_err = err_reg;

endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave with DEPTH 32-bit registers, transfer counter and an optional protocol
// checker enabled by defining APB_SLV_PROT_CHK_EN.
module apb_slave_regbank
  import apb_slv_pkg::*;
#(
  parameter int                    SEL_IDX   = 0,
  parameter int                    DEPTH     = 16,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [APB_DATA_W-1:0] RESET_VAL = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           Pselx,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [APB_ADDR_W-1:0] Paddr,
  input  logic [APB_DATA_W-1:0] Pwdata,
  output logic [APB_DATA_W-1:0] Prdata,
  output logic                  xfer_done,
  output logic [XFER_CNT_W-1:0] xfer_cnt,
  output logic                  prot_err
);

  localparam int IDX_W = $clog2(DEPTH);

  logic             sel;
  logic             hit;
  logic [IDX_W-1:0] idx;
  logic             unused_bits;

  assign sel         = Pselx[SEL_IDX];
  assign idx         = Paddr[IDX_W+1:2];
  assign hit         = Paddr[APB_ADDR_W-1:IDX_W+2] == BASE_ADDR[APB_ADDR_W-1:IDX_W+2];
  assign unused_bits = ^{Pselx, Paddr[1:0]};

  // state_reg is the bus phase of the previous cycle; state_next is the phase of this cycle
  apb_state_t state_reg, state_next;
  logic       rd_load, access_end, wr_commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = (sel && !Penable) ? SETUP : IDLE;
      SETUP:   state_next = (sel && Penable) ? ACCESS : IDLE;
      ACCESS: begin
        if (!sel)         state_next = IDLE;
        else if (!Penable) state_next = SETUP;
        else               state_next = ACCESS;
      end
      default: state_next = IDLE;
    endcase
  end

  // A repeated ACCESS (ACCESS -> ACCESS) is not a new access end, so it neither commits nor counts
  always_comb begin
    rd_load    = (state_next == SETUP) && !Pwrite;
    access_end = (state_reg == SETUP) && (state_next == ACCESS);
    wr_commit  = access_end && Pwrite && hit;
  end

  logic [APB_DATA_W-1:0] regs_reg [DEPTH];
  logic [DEPTH-1:0]      wr_en;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = wr_commit && (idx == IDX_W'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_reg[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) regs_reg[i] <= Pwdata;
      end
    end
  end

  logic [APB_DATA_W-1:0] prdata_reg, prdata_next;
  logic                  xfer_done_reg;
  logic [XFER_CNT_W-1:0] xfer_cnt_reg;

  // Prdata is non-zero only in the cycle after a read setup, so slaves can be OR-combined
  assign prdata_next = (rd_load && hit) ? regs_reg[idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prdata_reg    <= '0;
      xfer_done_reg <= 1'b0;
      xfer_cnt_reg  <= '0;
    end else begin
      prdata_reg    <= prdata_next;
      xfer_done_reg <= access_end;
      if (access_end) xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
    end
  end

  assign Prdata    = prdata_reg;
  assign xfer_done = xfer_done_reg;
  assign xfer_cnt  = xfer_cnt_reg;

`ifdef APB_SLV_PROT_CHK_EN
  apb_slv_prot_chk u_prot_chk (
    .clk      (clk),
    .rst      (rst),
    .state    (state_reg),
    .sel      (sel),
    .Penable  (Penable),
    .Pwrite   (Pwrite),
    .Paddr    (Paddr),
    .Pwdata   (Pwdata),
    .prot_err (prot_err)
  );
`else
  assign prot_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Scoreboard bench for apb_slave_regbank: expected transfer records are queued by the
// driver and retired on each xfer_done pulse.
module tb_apb_slave_regbank;
  localparam int          SEL_IDX   = 2;
  localparam int          DEPTH     = 16;
  localparam logic [31:0] BASE_ADDR = 32'h8000_0000;
`ifdef APB_SLV_PROT_CHK_EN
  localparam logic        CHK_EN = 1'b1;
`else
  localparam logic        CHK_EN = 1'b0;
`endif

  logic        clk, rst;
  logic [31:0] Pselx, Paddr, Pwdata, Prdata;
  logic        Penable, Pwrite, xfer_done, prot_err;
  logic [15:0] xfer_cnt;

  apb_slave_regbank #(
    .SEL_IDX   (SEL_IDX),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR),
    .RESET_VAL (32'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Pselx     (Pselx),
    .Penable   (Penable),
    .Pwrite    (Pwrite),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Prdata    (Prdata),
    .xfer_done (xfer_done),
    .xfer_cnt  (xfer_cnt),
    .prot_err  (prot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [31:0] rdata;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [DEPTH];
  int          cnt_model;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] prev_prdata = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h expected=%08h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %08h t=%0t", tag, got, $time);
    end
  endtask

  function automatic bit is_hit(input logic [31:0] addr);
    return (addr >> 6) == (BASE_ADDR >> 6);
  endfunction

  function automatic int widx(input logic [31:0] addr);
    logic [31:0] a;
    a = addr >> 2;
    return int'(a[3:0]);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    cnt_model = 0;
  endfunction

  // Starts at posedge+1; leaves the bus at posedge+1 after the access cycle, still selected.
  task automatic apb_xfer(input int sbit, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data);
    exp_t e;
    Pselx = 32'h1 << sbit; Pwrite = wr; Paddr = addr; Pwdata = data; Penable = 1'b0;
    @(posedge clk); #1;
    Penable = 1'b1;
    if (sbit == SEL_IDX) begin
      cnt_model++;
      e.is_rd = !wr;
      e.rdata = (!wr && is_hit(addr)) ? model[widx(addr)] : 32'h0;
      e.cnt   = cnt_model[15:0];
      if (wr && is_hit(addr)) model[widx(addr)] = data;
      sb_q.push_back(e);
    end else begin
      #3 check_eq("nosel_prdata", Prdata, 32'h0);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    Pselx = '0; Penable = 1'b0; Pwrite = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset is asserted away from any edge so its effect on outputs is purely asynchronous.
  task automatic pulse_reset();
    rst = 1'b1;
    Pselx = '0; Penable = 1'b0; Pwrite = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && xfer_done) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_xfer_done", 32'h1, 32'h0);
      end else begin
        e = sb_q.pop_front();
        check_eq("xfer_cnt", {16'h0, xfer_cnt}, {16'h0, e.cnt});
        if (e.is_rd) check_eq("rd_data", prev_prdata, e.rdata);
        check_eq("prdata_clr", Prdata, 32'h0);
      end
    end
    prev_prdata = Prdata;
  end

  initial begin
    rst = 1'b1; Pselx = '0; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_prdata",    Prdata,            32'h0);
    check_eq("rst_xfer_done", {31'h0, xfer_done}, 32'h0);
    check_eq("rst_xfer_cnt",  {16'h0, xfer_cnt}, 32'h0);
    check_eq("rst_prot_err",  {31'h0, prot_err}, 32'h0);
    rst = 1'b0;
    idle(1);

    apb_xfer(SEL_IDX, 1'b0, 32'h8000_000C, 32'h0);
    idle(2);

    // Back-to-back write then read of the same word
    apb_xfer(SEL_IDX, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    apb_xfer(SEL_IDX, 1'b0, 32'h8000_0010, 32'h0);
    idle(2);

    // Miss write must not alias onto word 0
    apb_xfer(SEL_IDX, 1'b1, 32'h9000_0000, 32'h1234_5678);
    apb_xfer(SEL_IDX, 1'b0, 32'h8000_0000, 32'h0);
    apb_xfer(SEL_IDX, 1'b0, 32'h9000_0010, 32'h0);
    idle(2);

    apb_xfer(SEL_IDX, 1'b1, 32'h8000_003C, 32'h0F0F_00FF);
    apb_xfer(SEL_IDX, 1'b0, 32'h8000_003F, 32'h0);
    apb_xfer(SEL_IDX, 1'b0, 32'h8000_0011, 32'h0);
    idle(2);

    apb_xfer(SEL_IDX + 1, 1'b1, 32'h8000_0010, 32'h5555_5555);
    apb_xfer(SEL_IDX + 1, 1'b0, 32'h8000_0010, 32'h0);
    idle(2);
    check_eq("nosel_cnt", {16'h0, xfer_cnt}, cnt_model);
    apb_xfer(SEL_IDX, 1'b0, 32'h8000_0010, 32'h0);
    idle(2);

    // Reset in the access cycle of a write
    Pselx = 32'h1 << SEL_IDX; Pwrite = 1'b1; Paddr = 32'h8000_0014; Pwdata = 32'hA5A5_A5A5;
    Penable = 1'b0;
    @(posedge clk); #1;
    Penable = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_prdata",    Prdata,            32'h0);
    check_eq("midrst_xfer_done", {31'h0, xfer_done}, 32'h0);
    check_eq("midrst_xfer_cnt",  {16'h0, xfer_cnt}, 32'h0);
    check_eq("midrst_prot_err",  {31'h0, prot_err}, 32'h0);
    pulse_reset();
    idle(1);
    apb_xfer(SEL_IDX, 1'b0, 32'h8000_0014, 32'h0);
    apb_xfer(SEL_IDX, 1'b0, 32'h8000_0010, 32'h0);
    idle(2);

    // Penable without a preceding setup
    Pselx = 32'h1 << SEL_IDX; Pwrite = 1'b0; Paddr = 32'h8000_0004; Penable = 1'b1;
    @(posedge clk); #1;
    idle(1);
    check_eq("idle_penable_err", {31'h0, prot_err}, {31'h0, CHK_EN});
    check_eq("idle_penable_cnt", {16'h0, xfer_cnt}, cnt_model);
    idle(3);
    check_eq("err_sticky", {31'h0, prot_err}, {31'h0, CHK_EN});

    pulse_reset();
    check_eq("err_cleared", {31'h0, prot_err}, 32'h0);
    apb_xfer(SEL_IDX, 1'b1, 32'h8000_0004, 32'h1111_1111);
    apb_xfer(SEL_IDX, 1'b1, 32'h8000_0008, 32'h2222_2222);
    idle(1);
    check_eq("legal_no_err", {31'h0, prot_err}, 32'h0);

    // Address moves between setup and access; read data comes from the setup address
    begin
      exp_t e;
      Pselx = 32'h1 << SEL_IDX; Pwrite = 1'b0; Paddr = 32'h8000_0004; Penable = 1'b0;
      @(posedge clk); #1;
      Penable = 1'b1; Paddr = 32'h8000_0008;
      cnt_model++;
      e.is_rd = 1'b1; e.rdata = model[1]; e.cnt = cnt_model[15:0];
      sb_q.push_back(e);
      @(posedge clk); #1;
    end
    idle(2);
    check_eq("addr_change_err", {31'h0, prot_err}, {31'h0, CHK_EN});

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    check_eq("sb_drain", sb_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
